pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port: Clk  in  1  sole clock, rising edge.
REQ-002 SHALL have port: Rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port: ID_rs, ID_rt  in  5 each  source registers of the instruction in ID.
REQ-004 SHALL have port: ID_UsesRs, ID_UsesRt  in  1 each  source-register-is-read qualifiers.
REQ-005 SHALL have port: EX_MemRead  in  1  the instruction in EX is a load.
REQ-006 SHALL have port: EX_WriteReg  in  5  resolved destination register of the instruction in EX.
REQ-007 SHALL have port: Br_Taken  in  1  branch resolved taken in ID this cycle.
REQ-008 SHALL have port: Mem_Busy  in  1  data memory not ready; the pipeline freezes.
REQ-009 SHALL have ports: Halt_Req, Resume  in  1 each  drain/halt request; restart from halted.
REQ-010 SHALL have ports: PC_Write, IFID_Write, IDEX_Write, EXMEM_Write  out  1 each  stage-register enables.
REQ-011 SHALL have ports: IFID_Flush, IDEX_Bubble  out  1 each  zero IF/ID; zero ID/EX control lines.
REQ-012 SHALL have ports: Halted  out  1; Stall_Cnt, Flush_Cnt  out  16 each; State  out  2.

Function
REQ-013 SHALL implement FSM states RUN=0, MEM_WAIT=1, DRAIN=2, HALTED=3, driven on State.
REQ-014 SHALL compute load-use LU = EX_MemRead & (EX_WriteReg!=0) & ((ID_UsesRs & ID_rs==EX_WriteReg) | (ID_UsesRt & ID_rt==EX_WriteReg)), combinationally.
REQ-015 SHALL use the RUN default: all four enables 1; IFID_Flush=0; IDEX_Bubble=0.
REQ-016 SHALL apply RUN priority Mem_Busy > Halt_Req > LU > Br_Taken, one action per cycle.
REQ-017 SHALL, in RUN with Mem_Busy: drive all enables 0 and go to MEM_WAIT with return flag = RUN.
REQ-018 SHALL, in RUN with Halt_Req (no Mem_Busy): go to DRAIN with drain count 0; this cycle behaves as a LU stall.
REQ-019 SHALL, in RUN with LU: drive PC_Write=0, IFID_Write=0, IDEX_Bubble=1, and suppress any concurrent Br_Taken flush.
REQ-020 SHALL, in RUN with Br_Taken only: drive IFID_Flush=1, with enables remaining 1.
REQ-021 SHALL, in MEM_WAIT: drive all enables 0, Flush=0, Bubble=0; on Mem_Busy=0, return to the flagged state (RUN/DRAIN), counts preserved.
REQ-022 SHALL, in DRAIN: drive PC_Write=0, IFID_Write=0, IDEX_Bubble=1, IDEX_Write=1, EXMEM_Write=1, and increment the 2-bit drain count.
REQ-023 SHALL move DRAIN to HALTED after the 3rd drain cycle; Mem_Busy in DRAIN SHALL go to MEM_WAIT (return=DRAIN) with the count held.
REQ-024 SHALL, in HALTED: drive all enables 0, Halted=1, ignore Halt_Req, and go to RUN on Resume.
REQ-025 SHALL increment Stall_Cnt each cycle PC_Write=0 in RUN/MEM_WAIT, saturating at 0xFFFF.
REQ-026 SHALL increment Flush_Cnt on each IFID_Flush=1, saturating at 0xFFFF.

Reset
REQ-027 SHALL, on Rst_n=0 (asynchronous), force State=RUN, drain count=0, return flag=RUN, Stall_Cnt=0, Flush_Cnt=0.
REQ-028 SHALL, while Rst_n=0, drive all enables 0, IFID_Flush=0, IDEX_Bubble=0, Halted=0.
REQ-029 SHALL treat reset mid-DRAIN/MEM_WAIT as abandoning the operation; first cycle after release is RUN.

Structure
REQ-030 SHALL place state encodings and the counter width (16) in the shared pipeline package.
REQ-031 SHALL keep LU detection in sub-module load_use_detect (purely combinational).
REQ-032 SHALL make all sequential logic a single always block on posedge Clk / negedge Rst_n.

Verification
REQ-033 SHALL cover: EX load to $5, ID add reads rs=$5 -> 1 cycle PC_Write=0, IDEX_Bubble=1, Stall_Cnt=1; EX_WriteReg=0 -> no stall.
REQ-034 SHALL cover: LU and Br_Taken same cycle -> stall, IFID_Flush=0; Br_Taken next cycle -> Flush=1, Flush_Cnt=1.
REQ-035 SHALL cover: Mem_Busy held 4 cycles in RUN -> 4 cycles all enables 0, State=1, Stall_Cnt=4, then RUN.
REQ-036 SHALL cover: Halt_Req -> 3 DRAIN cycles with bubbles, then Halted=1; Mem_Busy 2 cycles mid-drain -> HALTED 2 cycles later.
REQ-037 SHALL cover: Resume in HALTED -> RUN next cycle; Stall_Cnt forced to 0xFFFF -> stays 0xFFFF after another stall.
REQ-038 SHALL cover: Rst_n asserted mid-DRAIN, between edges -> outputs immediately reset values; State=0 after release.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
//------------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
//
// Shared pipeline-control definitions. The controller top and its testbench
// both see these through import pipe_hazard_ctrl_pkg::*.
//
// Contents
//   state_e      controller FSM encoding, also driven on the State output
//   CNT_W        width of the stall / flush event counters
//   DRAIN_LAST   drain-count value of the final drain cycle
//   ctrl_t       bundle of the six per-cycle pipeline control lines
//   CTRL_*       the three control patterns the FSM selects between
//   sat_inc()    saturating counter increment
//------------------------------------------------------------------------------
`timescale 1ns/1ps

package pipe_hazard_ctrl_pkg;

   localparam int CNT_W = 16;

   // Three drain cycles, numbered 0..2 by the drain count.
   localparam logic [1:0] DRAIN_LAST = 2'd2;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_DRAIN    = 2'd2,
      ST_HALTED   = 2'd3
   } state_e;

   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic idex_write;
      logic exmem_write;
      logic ifid_flush;
      logic idex_bubble;
   } ctrl_t;

   // Normal flow: every stage register advances.
   localparam ctrl_t CTRL_RUN    = '{pc_write: 1'b1, ifid_write: 1'b1,
                                     idex_write: 1'b1, exmem_write: 1'b1,
                                     ifid_flush: 1'b0, idex_bubble: 1'b0};

   // Whole pipeline frozen: nothing advances, nothing is cleared.
   localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0,
                                     idex_write: 1'b0, exmem_write: 1'b0,
                                     ifid_flush: 1'b0, idex_bubble: 1'b0};

   // Front end held, bubble injected into EX, back end keeps draining.
   // Used for load-use stalls, the halt-request cycle and every drain cycle.
   localparam ctrl_t CTRL_STALL  = '{pc_write: 1'b0, ifid_write: 1'b0,
                                     idex_write: 1'b1, exmem_write: 1'b1,
                                     ifid_flush: 1'b0, idex_bubble: 1'b1};

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/load_use_detect.sv
//------------------------------------------------------------------------------
// load_use_detect
//
// Purely combinational load-use hazard detector. Flags the case where the
// instruction in EX is a load whose destination is a register actually read
// by the instruction in ID. Register $0 is hard-wired to zero, so a load
// targeting it can never create a dependency.
//
// Ports
//   ex_mem_read   in   1  instruction in EX is a load
//   ex_write_reg  in   5  destination register of the instruction in EX
//   id_rs, id_rt  in   5  source registers of the instruction in ID
//   id_uses_rs    in   1  ID instruction really reads rs
//   id_uses_rt    in   1  ID instruction really reads rt
//   load_use      out  1  hazard present this cycle
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module load_use_detect (
   input  logic       ex_mem_read,
   input  logic [4:0] ex_write_reg,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rs,
   input  logic       id_uses_rt,
   output logic       load_use
);

   logic rs_hit;
   logic rt_hit;

   assign rs_hit   = id_uses_rs && (id_rs == ex_write_reg);
   assign rt_hit   = id_uses_rt && (id_rt == ex_write_reg);
   assign load_use = ex_mem_read && (ex_write_reg != 5'd0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
//------------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard / stall controller for a classic 5-stage pipeline. Produces the
// stage-register write enables, the IF/ID flush and the ID/EX bubble, and
// sequences memory-wait freezes and a drain-then-halt request.
//
// Ports
//   Clk                     in   1   rising-edge clock
//   Rst_n                   in   1   asynchronous active-low reset
//   ID_rs, ID_rt            in   5   source registers of the ID instruction
//   ID_UsesRs, ID_UsesRt    in   1   source-register-is-read qualifiers
//   EX_MemRead              in   1   EX instruction is a load
//   EX_WriteReg             in   5   destination register of EX instruction
//   Br_Taken                in   1   branch resolved taken in ID
//   Mem_Busy                in   1   data memory not ready, freeze pipeline
//   Halt_Req                in   1   drain the pipeline and halt
//   Resume                  in   1   leave HALTED
//   PC_Write .. EXMEM_Write out  1   stage-register enables
//   IFID_Flush              out  1   zero the IF/ID register
//   IDEX_Bubble             out  1   zero the ID/EX control lines
//   Halted                  out  1   controller is halted
//   Stall_Cnt               out  16  saturating count of front-end stall cycles
//   Flush_Cnt               out  16  saturating count of IF/ID flushes
//   State                   out  2   FSM state (RUN/MEM_WAIT/DRAIN/HALTED)
//
// Operation
//   RUN resolves one action per cycle with priority
//   Mem_Busy > Halt_Req > load-use > Br_Taken. A load-use stall squashes a
//   concurrent taken branch; the branch is presented again once the stall
//   clears. A halt request stalls like a load-use for one cycle, then three
//   DRAIN cycles let the back end empty before HALTED.
//
//   MEM_WAIT remembers whether it was entered from RUN or DRAIN. The pipeline
//   is frozen for exactly as many cycles as Mem_Busy is high: in the cycle
//   Mem_Busy falls the controller already behaves as the remembered state
//   (same outputs, same transitions), so leaving the wait costs no extra
//   cycle. State still reads MEM_WAIT during that release cycle.
//
//   Stall_Cnt counts PC_Write=0 cycles attributed to RUN or MEM_WAIT; drain
//   and halted cycles are not stalls. While Rst_n is low every enable and
//   every strobe output is forced low.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic [4:0]       ID_rs,
   input  logic [4:0]       ID_rt,
   input  logic             ID_UsesRs,
   input  logic             ID_UsesRt,
   input  logic             EX_MemRead,
   input  logic [4:0]       EX_WriteReg,
   input  logic             Br_Taken,
   input  logic             Mem_Busy,
   input  logic             Halt_Req,
   input  logic             Resume,
   output logic             PC_Write,
   output logic             IFID_Write,
   output logic             IDEX_Write,
   output logic             EXMEM_Write,
   output logic             IFID_Flush,
   output logic             IDEX_Bubble,
   output logic             Halted,
   output logic [CNT_W-1:0] Stall_Cnt,
   output logic [CNT_W-1:0] Flush_Cnt,
   output logic [1:0]       State
);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_e           state_q,     state_d;
   state_e           ret_q,       ret_d;
   logic [1:0]       drain_cnt_q, drain_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   // ---------------------------------------------------------------------
   // Combinational
   // ---------------------------------------------------------------------
   logic   load_use;
   state_e eff_state;     // state whose behaviour applies this cycle
   ctrl_t  ctrl;
   logic   halted_int;
   logic   count_stall;

   load_use_detect u_load_use_detect (
      .ex_mem_read  (EX_MemRead),
      .ex_write_reg (EX_WriteReg),
      .id_rs        (ID_rs),
      .id_rt        (ID_rt),
      .id_uses_rs   (ID_UsesRs),
      .id_uses_rt   (ID_UsesRt),
      .load_use     (load_use)
   );

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the case can leave one unassigned and infer a latch.
      eff_state   = state_q;
      ctrl        = CTRL_RUN;
      halted_int  = 1'b0;
      state_d     = state_q;
      ret_d       = ret_q;
      drain_cnt_d = drain_cnt_q;

      // Memory released this cycle: act as the state we are returning to.
      if ((state_q == ST_MEM_WAIT) && !Mem_Busy) begin
         eff_state = ret_q;
      end

      unique case (eff_state)
         ST_RUN: begin
            state_d = ST_RUN;
            if (Mem_Busy) begin
               ctrl    = CTRL_FREEZE;
               state_d = ST_MEM_WAIT;
               ret_d   = ST_RUN;
            end else if (Halt_Req) begin
               ctrl        = CTRL_STALL;
               state_d     = ST_DRAIN;
               drain_cnt_d = 2'd0;
            end else if (load_use) begin
               // The stall wins over a taken branch in the same cycle.
               ctrl = CTRL_STALL;
            end else begin
               ctrl            = CTRL_RUN;
               ctrl.ifid_flush = Br_Taken;
            end
         end

         // Only reached with Mem_Busy high; the release case was remapped.
         ST_MEM_WAIT: begin
            ctrl = CTRL_FREEZE;
         end

         ST_DRAIN: begin
            if (Mem_Busy) begin
               ctrl    = CTRL_FREEZE;
               state_d = ST_MEM_WAIT;
               ret_d   = ST_DRAIN;
            end else begin
               ctrl        = CTRL_STALL;
               drain_cnt_d = drain_cnt_q + 2'd1;
               state_d     = (drain_cnt_q == DRAIN_LAST) ? ST_HALTED : ST_DRAIN;
            end
         end

         ST_HALTED: begin
            ctrl       = CTRL_FREEZE;
            halted_int = 1'b1;
            if (Resume) begin
               state_d = ST_RUN;
            end
         end

         default: begin
            ctrl    = CTRL_FREEZE;
            state_d = ST_RUN;
         end
      endcase

      count_stall = !ctrl.pc_write &&
                    ((eff_state == ST_RUN) || (eff_state == ST_MEM_WAIT));
   end

   // ---------------------------------------------------------------------
   // Sequential
   // ---------------------------------------------------------------------
   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q     <= ST_RUN;
         ret_q       <= ST_RUN;
         drain_cnt_q <= 2'd0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         ret_q       <= ret_d;
         drain_cnt_q <= drain_cnt_d;
         if (count_stall) begin
            stall_cnt_q <= sat_inc(stall_cnt_q);
         end
         if (ctrl.ifid_flush) begin
            flush_cnt_q <= sat_inc(flush_cnt_q);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs: all enables and strobes low for as long as reset is held.
   // ---------------------------------------------------------------------
   assign PC_Write    = Rst_n && ctrl.pc_write;
   assign IFID_Write  = Rst_n && ctrl.ifid_write;
   assign IDEX_Write  = Rst_n && ctrl.idex_write;
   assign EXMEM_Write = Rst_n && ctrl.exmem_write;
   assign IFID_Flush  = Rst_n && ctrl.ifid_flush;
   assign IDEX_Bubble = Rst_n && ctrl.idex_bubble;
   assign Halted      = Rst_n && halted_int;
   assign Stall_Cnt   = stall_cnt_q;
   assign Flush_Cnt   = flush_cnt_q;
   assign State       = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
//------------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed-vector bench with a scoreboard. Inputs change on the falling
// edge; the expected outputs for that cycle are queued at the same time.
// A monitor samples the DUT 3 ns later (2 ns before the rising edge) and
// compares against the head of the queue.
// Expected en field is {PC_Write, IFID_Write, IDEX_Write, EXMEM_Write}.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pipe_hazard_ctrl;

   logic        Clk;
   logic        Rst_n;
   logic [4:0]  ID_rs, ID_rt;
   logic        ID_UsesRs, ID_UsesRt;
   logic        EX_MemRead;
   logic [4:0]  EX_WriteReg;
   logic        Br_Taken, Mem_Busy, Halt_Req, Resume;
   logic        PC_Write, IFID_Write, IDEX_Write, EXMEM_Write;
   logic        IFID_Flush, IDEX_Bubble, Halted;
   logic [15:0] Stall_Cnt, Flush_Cnt;
   logic [1:0]  State;

   typedef struct packed {
      logic [1:0]  st;
      logic [3:0]  en;
      logic        fl;
      logic        bub;
      logic        hlt;
      logic [15:0] sc;
      logic [15:0] fc;
   } exp_t;

   exp_t exp_q[$];
   int   vec_cnt    = 0;
   int   miscompare = 0;

   pipe_hazard_ctrl dut (
      .Clk         (Clk),
      .Rst_n       (Rst_n),
      .ID_rs       (ID_rs),
      .ID_rt       (ID_rt),
      .ID_UsesRs   (ID_UsesRs),
      .ID_UsesRt   (ID_UsesRt),
      .EX_MemRead  (EX_MemRead),
      .EX_WriteReg (EX_WriteReg),
      .Br_Taken    (Br_Taken),
      .Mem_Busy    (Mem_Busy),
      .Halt_Req    (Halt_Req),
      .Resume      (Resume),
      .PC_Write    (PC_Write),
      .IFID_Write  (IFID_Write),
      .IDEX_Write  (IDEX_Write),
      .EXMEM_Write (EXMEM_Write),
      .IFID_Flush  (IFID_Flush),
      .IDEX_Bubble (IDEX_Bubble),
      .Halted      (Halted),
      .Stall_Cnt   (Stall_Cnt),
      .Flush_Cnt   (Flush_Cnt),
      .State       (State)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input int idx, input exp_t got, input exp_t e);
      if (got !== e) begin
         miscompare++;
         $display("FAIL vec %0d: got st=%0d en=%b fl=%b bub=%b hlt=%b sc=%h fc=%h, exp st=%0d en=%b fl=%b bub=%b hlt=%b sc=%h fc=%h",
                  idx, got.st, got.en, got.fl, got.bub, got.hlt, got.sc, got.fc,
                  e.st, e.en, e.fl, e.bub, e.hlt, e.sc, e.fc);
      end
   endtask

   // Monitor: pops one expectation per cycle in which a vector was applied.
   initial begin
      exp_t e;
      exp_t got;
      forever begin
         @(negedge Clk);
         #3;
         if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            got = {State, PC_Write, IFID_Write, IDEX_Write, EXMEM_Write,
                   IFID_Flush, IDEX_Bubble, Halted, Stall_Cnt, Flush_Cnt};
            check(vec_cnt, got, e);
            vec_cnt++;
         end
      end
   end

   // One cycle of stimulus plus its expected response.
   task automatic step(
      input logic        rst_v,
      input logic [4:0]  rs, rt,
      input logic        urs, urt, mr,
      input logic [4:0]  wr,
      input logic        br, busy, halt, res,
      input logic [1:0]  st,
      input logic [3:0]  en,
      input logic        fl, bub, hlt,
      input logic [15:0] sc, fc);
      exp_t e;
      @(negedge Clk);
      Rst_n       = rst_v;
      ID_rs       = rs;
      ID_rt       = rt;
      ID_UsesRs   = urs;
      ID_UsesRt   = urt;
      EX_MemRead  = mr;
      EX_WriteReg = wr;
      Br_Taken    = br;
      Mem_Busy    = busy;
      Halt_Req    = halt;
      Resume      = res;
      e = '{st: st, en: en, fl: fl, bub: bub, hlt: hlt, sc: sc, fc: fc};
      exp_q.push_back(e);
   endtask

   initial begin
      Rst_n = 1'b0; ID_rs = '0; ID_rt = '0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0;
      EX_MemRead = 1'b0; EX_WriteReg = '0; Br_Taken = 1'b0; Mem_Busy = 1'b0;
      Halt_Req = 1'b0; Resume = 1'b0;

      //   rst rs rt urs urt mr wr br bsy hlt res | st en      fl bub hlt sc   fc
      // Reset held: everything low.
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 4'b0000, 0, 0, 0, 16'd0, 16'd0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 4'b0000, 0, 0, 0, 16'd0, 16'd0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 4'b1111, 0, 0, 0, 16'd0, 16'd0);
      // Load to $5, add reads rs=$5: one stall cycle.
      step(1, 5, 0, 1, 0, 1, 5, 0, 0, 0, 0,   0, 4'b0011, 0, 1, 0, 16'd0, 16'd0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 4'b1111, 0, 0, 0, 16'd1, 16'd0);
      // Load to $0: no stall.
      step(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0,   0, 4'b1111, 0, 0, 0, 16'd1, 16'd0);
      // rt matches but is not read: no stall.
      step(1, 3, 7, 1, 0, 1, 7, 0, 0, 0, 0,   0, 4'b1111, 0, 0, 0, 16'd1, 16'd0);
      // rt matches and is read: stall.
      step(1, 0, 7, 0, 1, 1, 7, 0, 0, 0, 0,   0, 4'b0011, 0, 1, 0, 16'd1, 16'd0);
      // Match but EX is not a load: no stall.
      step(1, 0, 7, 0, 1, 0, 7, 0, 0, 0, 0,   0, 4'b1111, 0, 0, 0, 16'd2, 16'd0);
      // Load-use with taken branch: stall, no flush. Then branch alone flushes.
      step(1, 5, 0, 1, 0, 1, 5, 1, 0, 0, 0,   0, 4'b0011, 0, 1, 0, 16'd2, 16'd0);
      step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,   0, 4'b1111, 1, 0, 0, 16'd3, 16'd0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 4'b1111, 0, 0, 0, 16'd3, 16'd1);
      // Mem_Busy for 4 cycles from RUN: 4 frozen cycles, Stall_Cnt +4.
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 4'b0000, 0, 0, 0, 16'd3, 16'd1);
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   1, 4'b0000, 0, 0, 0, 16'd4, 16'd1);
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   1, 4'b0000, 0, 0, 0, 16'd5, 16'd1);
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   1, 4'b0000, 0, 0, 0, 16'd6, 16'd1);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 4'b1111, 0, 0, 0, 16'd7, 16'd1);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 4'b1111, 0, 0, 0, 16'd7, 16'd1);
      // Everything at once: Mem_Busy wins. Release cycle takes the branch.
      step(1, 5, 0, 1, 0, 1, 5, 1, 1, 1, 0,   0, 4'b0000, 0, 0, 0, 16'd7, 16'd1);
      step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,   1, 4'b1111, 1, 0, 0, 16'd8, 16'd1);
      // Halt with branch: halt wins; 3 drain cycles then HALTED.
      step(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0,   0, 4'b0011, 0, 1, 0, 16'd8, 16'd2);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   2, 4'b0011, 0, 1, 0, 16'd9, 16'd2);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   2, 4'b0011, 0, 1, 0, 16'd9, 16'd2);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   2, 4'b0011, 0, 1, 0, 16'd9, 16'd2);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   3, 4'b0000, 0, 0, 1, 16'd9, 16'd2);
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,   3, 4'b0000, 0, 0, 1, 16'd9, 16'd2);
      // Resume: RUN on the next cycle.
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   3, 4'b0000, 0, 0, 1, 16'd9, 16'd2);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 4'b1111, 0, 0, 0, 16'd9, 16'd2);
      // Halt again with Mem_Busy for 2 cycles mid-drain: HALTED 2 cycles later.
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 4'b0011, 0, 1, 0, 16'd9, 16'd2);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   2, 4'b0011, 0, 1, 0, 16'd10, 16'd2);
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   2, 4'b0000, 0, 0, 0, 16'd10, 16'd2);
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   1, 4'b0000, 0, 0, 0, 16'd10, 16'd2);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 4'b0011, 0, 1, 0, 16'd11, 16'd2);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   2, 4'b0011, 0, 1, 0, 16'd11, 16'd2);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   3, 4'b0000, 0, 0, 1, 16'd11, 16'd2);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   3, 4'b0000, 0, 0, 1, 16'd11, 16'd2);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 4'b1111, 0, 0, 0, 16'd11, 16'd2);
      // Stall counter pinned at 0xFFFF across a stall edge, then released.
      step(1, 5, 0, 1, 0, 1, 5, 0, 0, 0, 0,   0, 4'b0011, 0, 1, 0, 16'hFFFF, 16'd2);
      force dut.stall_cnt_q = 16'hFFFF;
      step(1, 5, 0, 1, 0, 1, 5, 0, 0, 0, 0,   0, 4'b0011, 0, 1, 0, 16'hFFFF, 16'd2);
      release dut.stall_cnt_q;
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 4'b1111, 0, 0, 0, 16'hFFFF, 16'd2);
      // Reset asserted mid-drain, between clock edges.
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 4'b0011, 0, 1, 0, 16'hFFFF, 16'd2);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   2, 4'b0011, 0, 1, 0, 16'hFFFF, 16'd2);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 4'b0000, 0, 0, 0, 16'd0, 16'd0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 4'b1111, 0, 0, 0, 16'd0, 16'd0);
      step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,   0, 4'b1111, 1, 0, 0, 16'd0, 16'd0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 4'b1111, 0, 0, 0, 16'd0, 16'd1);

      @(negedge Clk);
      #5;
      if (exp_q.size() != 0) begin
         miscompare++;
         $display("FAIL drain_queue: %0d expectations left unchecked, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare);
      $finish;
   end

endmodule
